// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register index width,
// EX operand forward-select encodings and the forward priority rule.
package hazard_ctrl_pkg;

  localparam int RegNumWidth = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwdSel_e;

  // MEM wins over WB; a load still in MEM has no data yet, so it never forwards.
  function automatic fwdSel_e fwdPick(input logic memHit, input logic memIsLoad,
                                      input logic wbHit);
    if (memHit) return memIsLoad ? FWD_REG : FWD_MEM;
    if (wbHit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side (master)
// presents the ID instruction and branch outcome; the controller (slave) drives
// stage enables/clears and the EX forward selects.
interface hazard_ctrl_if #(
  parameter int REG_NUM_WIDTH = hazard_ctrl_pkg::RegNumWidth
);
  logic                     idValid;
  logic [REG_NUM_WIDTH-1:0] idRs1;
  logic [REG_NUM_WIDTH-1:0] idRs2;
  logic                     idUsesRs1;
  logic                     idUsesRs2;
  logic [REG_NUM_WIDTH-1:0] idRd;
  logic                     idRegWrite;
  logic                     idIsLoad;
  logic                     idIsMdu;
  logic                     exBranchTaken;

  logic                     stallIF;
  logic                     stallID;
  logic                     flushID;
  logic                     stallEX;
  logic                     bubbleEX;
  logic                     bubbleMEM;
  logic [1:0]               fwdSelA;
  logic [1:0]               fwdSelB;
  logic                     mduBusy;

  modport master (
    output idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRegWrite,
           idIsLoad, idIsMdu, exBranchTaken,
    input  stallIF, stallID, flushID, stallEX, bubbleEX, bubbleMEM,
           fwdSelA, fwdSelB, mduBusy
  );

  modport slave (
    input  idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRegWrite,
           idIsLoad, idIsMdu, exBranchTaken,
    output stallIF, stallID, flushID, stallEX, bubbleEX, bubbleMEM,
           fwdSelA, fwdSelB, mduBusy
  );
endinterface

// File: rtl/hazard_ctrl_mdu_busy_counter.sv
// MUL/DIV occupancy counter: loads MDU_LATENCY-1 when an MDU op enters EX and
// counts down to zero; busy while non-zero, so EX is held MDU_LATENCY cycles.
module mdu_busy_counter #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_WIDTH   = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic busy
);
  localparam logic [CNT_WIDTH-1:0] LoadVal = CNT_WIDTH'(MDU_LATENCY - 1);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            cnt <= '0;
    else if (load)        cnt <= LoadVal;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM scoreboard, load-use stall,
// taken-branch flush, MDU occupancy of EX and registered EX forward selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_WIDTH = RegNumWidth,
  parameter int MDU_LATENCY   = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_ctrl_if.slave hc
);
  typedef logic [REG_NUM_WIDTH-1:0] regNum_t;

  typedef struct packed {
    logic    valid;
    regNum_t rd;
    logic    regWrite;
    logic    isLoad;
  } stage_t;

  typedef struct packed {
    stage_t  dst;
    regNum_t rs1;
    regNum_t rs2;
    logic    useRs1;
    logic    useRs2;
    logic    isMdu;
  } exStage_t;

  function automatic logic srcHit(input logic valid, input logic regWrite,
                                  input regNum_t rd, input regNum_t rs,
                                  input logic useRs);
    return valid && regWrite && (rd == rs) && (rs != '0) && useRs;
  endfunction

  exStage_t ex, exNext, idEntry;
  stage_t   mem, memNext;
  fwdSel_e  fwdA, fwdB, fwdANext, fwdBNext;
  logic     mduBusy, mduStart, loadUse, branch;
  logic     stallEX, bubbleEX, bubbleMEM;
  logic     exUse1, exUse2;

  mdu_busy_counter #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_mdu (
    .clk  (clk),
    .rstn (rstn),
    .load (mduStart),
    .busy (mduBusy)
  );

  always_comb begin
    idEntry              = '0;
    idEntry.dst.valid    = hc.idValid;
    idEntry.dst.rd       = hc.idRd;
    idEntry.dst.regWrite = hc.idRegWrite;
    idEntry.dst.isLoad   = hc.idIsLoad;
    idEntry.rs1          = hc.idRs1;
    idEntry.rs2          = hc.idRs2;
    idEntry.useRs1       = hc.idUsesRs1;
    idEntry.useRs2       = hc.idUsesRs2;
    idEntry.isMdu        = hc.idIsMdu;

    // Front end is frozen during MDU occupancy, so load-use is moot then.
    loadUse = hc.idValid && !mduBusy && ex.dst.isLoad &&
              (srcHit(ex.dst.valid, ex.dst.regWrite, ex.dst.rd, hc.idRs1, hc.idUsesRs1) ||
               srcHit(ex.dst.valid, ex.dst.regWrite, ex.dst.rd, hc.idRs2, hc.idUsesRs2));
    branch    = rstn && hc.exBranchTaken && !mduBusy;
    stallEX   = mduBusy;
    bubbleEX  = branch || loadUse;
    bubbleMEM = mduBusy;
    mduStart  = !stallEX && !bubbleEX && hc.idValid && hc.idIsMdu;

    if (stallEX)       exNext = ex;
    else if (bubbleEX) exNext = '0;
    else               exNext = idEntry;

    if (bubbleMEM) memNext = '0;
    else           memNext = ex.dst;

    // Next-WB is exactly the current MEM entry, so no WB register is kept.
    exUse1   = exNext.useRs1 && exNext.dst.valid;
    exUse2   = exNext.useRs2 && exNext.dst.valid;
    fwdANext = fwdPick(srcHit(memNext.valid, memNext.regWrite, memNext.rd, exNext.rs1, exUse1),
                       memNext.isLoad,
                       srcHit(mem.valid, mem.regWrite, mem.rd, exNext.rs1, exUse1));
    fwdBNext = fwdPick(srcHit(memNext.valid, memNext.regWrite, memNext.rd, exNext.rs2, exUse2),
                       memNext.isLoad,
                       srcHit(mem.valid, mem.regWrite, mem.rd, exNext.rs2, exUse2));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex   <= '0;
      mem  <= '0;
      fwdA <= FWD_REG;
      fwdB <= FWD_REG;
    end else begin
      ex   <= exNext;
      mem  <= memNext;
      fwdA <= fwdANext;
      fwdB <= fwdBNext;
    end
  end

  assign hc.stallIF   = mduBusy || (loadUse && !branch);
  assign hc.stallID   = mduBusy || (loadUse && !branch);
  assign hc.flushID   = branch;
  assign hc.stallEX   = stallEX;
  assign hc.bubbleEX  = bubbleEX;
  assign hc.bubbleMEM = bubbleMEM;
  assign hc.fwdSelA   = fwdA;
  assign hc.fwdSelB   = fwdB;
  assign hc.mduBusy   = mduBusy;

  // A redirect cannot originate from EX while an MDU op owns it.
  assert property (@(posedge clk) disable iff (!rstn) !(hc.exBranchTaken && mduBusy))
    else $error("hazard_ctrl: exBranchTaken asserted while MDU busy");

  assert property (@(posedge clk) disable iff (!rstn) mduBusy |-> ex.isMdu)
    else $error("hazard_ctrl: MDU busy without an MDU op in EX");

  // Load-use stalling guarantees EX never consumes a load still in MEM.
  assert property (@(posedge clk) disable iff (!rstn)
    !(mem.isLoad &&
      (srcHit(mem.valid, mem.regWrite, mem.rd, ex.rs1, ex.useRs1 && ex.dst.valid) ||
       srcHit(mem.valid, mem.regWrite, mem.rd, ex.rs2, ex.useRs2 && ex.dst.valid))))
    else $error("hazard_ctrl: EX depends on a load in MEM");
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed per-cycle vector table, mid-MDU reset
// sequence, then randomized instruction streams against an instruction-level model.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, ld, mdu;
  } instr_t;

  typedef struct {
    instr_t      id;
    logic        br;
    logic [10:0] exp;
  } vec_t;

  // {stallIF, stallID, flushID, stallEX, bubbleEX, bubbleMEM, fwdA, fwdB, mduBusy}
  localparam logic [10:0] Z    = 11'b0;
  localparam logic [10:0] LU   = 11'b11001000000;
  localparam logic [10:0] BUSY = 11'b11010100001;
  localparam logic [10:0] BR   = 11'b00101000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_NUM_WIDTH(5)) hc();

  hazard_ctrl #(
    .REG_NUM_WIDTH (5),
    .MDU_LATENCY   (LAT),
    .CNT_WIDTH     (3)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .hc   (hc.slave)
  );

  logic [10:0] dutOut;
  assign dutOut = {hc.stallIF, hc.stallID, hc.flushID, hc.stallEX, hc.bubbleEX,
                   hc.bubbleMEM, hc.fwdSelA, hc.fwdSelB, hc.mduBusy};

  function automatic logic [10:0] F(input logic [1:0] a, input logic [1:0] b);
    return {6'b0, a, b, 1'b0};
  endfunction

  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.u1 = 1'b1; i.u2 = 1'b1; i.we = 1'b1;
    return i;
  endfunction

  function automatic instr_t aluI(input int rd, input int rs1);
    instr_t i;
    i = alu(rd, rs1, 0);
    i.u2 = 1'b0;
    return i;
  endfunction

  function automatic instr_t lw(input int rd, input int rs1);
    instr_t i;
    i = aluI(rd, rs1);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t mul(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = alu(rd, rs1, rs2);
    i.mdu = 1'b1;
    return i;
  endfunction

  // ---- instruction-level reference model ----
  instr_t      mEx, mMem, mWb;   // instruction in EX, and the last two to leave EX
  int          mLeft;            // further cycles the MDU op must stay in EX
  logic [1:0]  mFwdA, mFwdB;

  function automatic logic dep(input instr_t p, input logic [4:0] rs, input logic u);
    return p.v && p.we && u && (rs != 5'd0) && (p.rd == rs);
  endfunction

  function automatic logic [1:0] fwdOf(input logic [4:0] rs, input logic u);
    if (dep(mMem, rs, u)) return mMem.ld ? 2'b00 : 2'b01;
    if (dep(mWb, rs, u))  return 2'b10;
    return 2'b00;
  endfunction

  task automatic modelEval(input instr_t id, input logic br,
                           output logic busy, output logic lu, output logic bt);
    busy = (mLeft != 0);
    lu   = !busy && id.v && mEx.ld && (dep(mEx, id.rs1, id.u1) || dep(mEx, id.rs2, id.u2));
    bt   = br && !busy;
  endtask

  function automatic logic [10:0] modelOut(input logic busy, input logic lu, input logic bt);
    logic st;
    st = busy || (lu && !bt);
    return {st, st, bt, busy, bt || lu, busy, mFwdA, mFwdB, busy};
  endfunction

  task automatic modelAdvance(input instr_t id, input logic br);
    logic busy, lu, bt;
    modelEval(id, br, busy, lu, bt);
    mWb = mMem;
    if (busy) begin
      mMem  = '0;
      mLeft = mLeft - 1;
    end else begin
      mMem = mEx;
      mEx  = (bt || lu || !id.v) ? '0 : id;
      if (mEx.v && mEx.mdu) mLeft = LAT - 1;
    end
    mFwdA = fwdOf(mEx.rs1, mEx.u1 && mEx.v);
    mFwdB = fwdOf(mEx.rs2, mEx.u2 && mEx.v);
  endtask

  task automatic modelReset();
    mEx = '0; mMem = '0; mWb = '0; mLeft = 0; mFwdA = 2'b00; mFwdB = 2'b00;
  endtask

  // ---- stimulus / checking ----
  task automatic drive(input instr_t i, input logic br);
    hc.idValid = i.v;  hc.idRs1 = i.rs1;  hc.idRs2 = i.rs2;
    hc.idUsesRs1 = i.u1;  hc.idUsesRs2 = i.u2;  hc.idRd = i.rd;
    hc.idRegWrite = i.we;  hc.idIsLoad = i.ld;  hc.idIsMdu = i.mdu;
    hc.exBranchTaken = br;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    checks++;
    if (dutOut !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, dutOut, exp);
    end
  endtask

  // One clock: drive at negedge, check after settle, model steps on the posedge.
  task automatic cycle(input string name, input instr_t id, input logic br,
                       input logic useModel, input logic [10:0] tblExp);
    logic busy, lu, bt;
    @(negedge clk);
    drive(id, br);
    #1;
    modelEval(id, br, busy, lu, bt);
    check(name, useModel ? modelOut(busy, lu, bt) : tblExp);
    @(posedge clk);
    modelAdvance(id, br);
  endtask

  function automatic instr_t randInstr();
    instr_t r;
    int     k;
    r     = '0;
    r.v   = ($urandom_range(0, 4) != 0);
    r.rs1 = 5'($urandom_range(0, 3));
    r.rs2 = 5'($urandom_range(0, 3));
    r.rd  = 5'($urandom_range(0, 3));
    r.u1  = ($urandom_range(0, 1) == 1);
    r.u2  = ($urandom_range(0, 1) == 1);
    r.we  = ($urandom_range(0, 3) != 0);
    k     = $urandom_range(0, 9);
    r.ld  = (k < 3);
    r.mdu = (k == 3);
    return r;
  endfunction

  vec_t tbl [32];

  initial begin
    instr_t nop;
    nop = '0;

    tbl[0]  = '{alu(5, 20, 21), 1'b0, Z};         // add x5
    tbl[1]  = '{alu(6, 5, 7),   1'b0, Z};         // sub x6,x5,x7 back-to-back
    tbl[2]  = '{nop,            1'b0, F(2'b01, 2'b00)};
    tbl[3]  = '{nop,            1'b0, Z};
    tbl[4]  = '{alu(5, 20, 21), 1'b0, Z};         // add x5; nop; or x8,x5,x5
    tbl[5]  = '{nop,            1'b0, Z};
    tbl[6]  = '{alu(8, 5, 5),   1'b0, Z};
    tbl[7]  = '{nop,            1'b0, F(2'b10, 2'b10)};
    tbl[8]  = '{nop,            1'b0, Z};
    tbl[9]  = '{lw(9, 20),      1'b0, Z};         // lw x9; add x10,x9,x0
    tbl[10] = '{alu(10, 9, 0),  1'b0, LU};
    tbl[11] = '{alu(10, 9, 0),  1'b0, Z};
    tbl[12] = '{nop,            1'b0, F(2'b10, 2'b00)};
    tbl[13] = '{nop,            1'b0, Z};
    tbl[14] = '{aluI(0, 20),    1'b0, Z};         // addi x0; add x1,x0,x0
    tbl[15] = '{alu(1, 0, 0),   1'b0, Z};
    tbl[16] = '{nop,            1'b0, Z};
    tbl[17] = '{lw(0, 20),      1'b0, Z};         // lw x0 never causes load-use
    tbl[18] = '{alu(1, 0, 0),   1'b0, Z};
    tbl[19] = '{nop,            1'b0, Z};
    tbl[20] = '{nop,            1'b0, Z};
    tbl[21] = '{mul(3, 20, 21), 1'b0, Z};         // mul x3; add x4,x3,x0
    tbl[22] = '{alu(4, 3, 0),   1'b0, BUSY};
    tbl[23] = '{alu(4, 3, 0),   1'b0, BUSY};
    tbl[24] = '{alu(4, 3, 0),   1'b0, BUSY};
    tbl[25] = '{alu(4, 3, 0),   1'b0, Z};
    tbl[26] = '{nop,            1'b0, F(2'b01, 2'b00)};
    tbl[27] = '{nop,            1'b0, Z};
    tbl[28] = '{lw(9, 20),      1'b0, Z};         // branch beats load-use
    tbl[29] = '{alu(10, 9, 0),  1'b1, BR};
    tbl[30] = '{nop,            1'b0, Z};
    tbl[31] = '{nop,            1'b0, Z};

    modelReset();
    drive(nop, 1'b0);
    repeat (2) @(negedge clk);
    drive(alu(5, 20, 21), 1'b1);
    #1;
    check("reset_state", Z);
    @(negedge clk);
    drive(nop, 1'b0);
    rstn = 1'b1;

    for (int k = 0; k < 32; k++)
      cycle($sformatf("tbl%0d", k), tbl[k].id, tbl[k].br, 1'b0, tbl[k].exp);

    // Reset pulse in the middle of an MDU op.
    cycle("mdu_start", mul(3, 20, 21), 1'b0, 1'b0, Z);
    cycle("mdu_busy0", nop, 1'b0, 1'b0, BUSY);
    #2;
    rstn = 1'b0;
    drive(alu(5, 20, 21), 1'b1);
    #1;
    check("mid_mdu_reset", Z);
    modelReset();
    @(negedge clk);
    drive(nop, 1'b0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++)
      cycle($sformatf("post_reset%0d", k), nop, 1'b0, 1'b0, Z);

    for (int n = 0; n < 500; n++) begin
      instr_t r;
      logic   b;
      r = randInstr();
      b = (mLeft == 0) && ($urandom_range(0, 9) == 0);
      cycle($sformatf("rand%0d", n), r, b, 1'b1, Z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers per stage and produces registered forwarding selects for the EX operand muxes.
- Sequences the pipeline: load-use stalls, taken-branch flushes, and multi-cycle MUL/DIV (MDU) occupancy of EX.
- Sits beside the pipeline registers and drives their enable/clear inputs.

Parameters:
- REG_NUM_WIDTH, 5, register index width.
- MDU_LATENCY, 4, total EX cycles of an MDU op (>=2).
- CNT_WIDTH, 3, MDU counter width; must hold MDU_LATENCY-1.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- idValid  in  1  ID holds a real instruction.
- idRs1  in  REG_NUM_WIDTH  ID source 1.
- idRs2  in  REG_NUM_WIDTH  ID source 2.
- idUsesRs1  in  1  ID instruction reads rs1.
- idUsesRs2  in  1  ID instruction reads rs2.
- idRd  in  REG_NUM_WIDTH  ID destination.
- idRegWrite  in  1  ID instruction writes rd.
- idIsLoad  in  1  ID instruction is a load.
- idIsMdu  in  1  ID instruction is MUL/DIV.
- exBranchTaken  in  1  branch/jump in EX redirects PC this cycle.
- stallIF  out  1  hold PC.
- stallID  out  1  hold IF/ID register.
- flushID  out  1  clear IF/ID register.
- stallEX  out  1  hold ID/EX register.
- bubbleEX  out  1  load NOP into ID/EX.
- bubbleMEM  out  1  load NOP into EX/MEM.
- fwdSelA  out  2  EX operand A: 00 regfile, 01 MEM result, 10 WB result.
- fwdSelB  out  2  EX operand B, same encoding.
- mduBusy  out  1  MDU op occupying EX.

Behaviour:
- Per-stage scoreboard for EX, MEM and WB: {valid, rd, regWrite, isLoad}. EX additionally holds rs1, rs2, use bits and isMdu.
- Async reset: all scoreboard valids 0, MDU counter 0, every output 0 (fwdSel 00). Normal operation resumes on the first clock edge after rstn rises. Reset mid-MDU abandons the op.
- Match rule: a stage matches source rs when valid && regWrite && rd == rs && rs != 0 && use bit set. x0 never matches.
- Load-use (combinational): idValid and ID rs matches EX with EX.isLoad.
  - Output: stallIF = stallID = bubbleEX = 1 for exactly 1 cycle.
  - The next cycle the load is in MEM and is forwarded via 01? No: load data is only available from WB, so the dependent instruction uses WB forwarding (10).
- Taken branch: exBranchTaken gives flushID = 1 and bubbleEX = 1.
  - Branch beats load-use: stall outputs are 0 that cycle.
  - Net result: 2 squashed slots.
- MDU:
  - On the edge an MDU op enters EX, the counter loads MDU_LATENCY-1.
  - While counter != 0: mduBusy = stallIF = stallID = stallEX = bubbleMEM = 1, and the counter decrements each cycle.
  - The op leaves EX on the cycle the counter reads 0, so EX occupancy is exactly MDU_LATENCY cycles.
  - Load-use detection is suppressed while mduBusy, since the front end is frozen anyway.
  - exBranchTaken while mduBusy is illegal; flag it with a simulation assertion and ignore it.
- Scoreboard advance each edge:
  - WB <= MEM.
  - MEM <= bubbleMEM ? invalid : EX.
  - EX <= stallEX ? EX : (bubbleEX ? invalid : ID fields qualified by idValid).
- Forward selects are registered on the same edge that loads EX, so they are valid for the whole EX cycle. They are computed from the next-EX sources against the next-MEM/next-WB contents.
  - MEM has priority over WB.
  - A matching MEM entry that is a load gives 00. This cannot occur, because load-use stall prevents it.
- Latency: control outputs are combinational from current state plus ID/branch inputs. Forwarding selects have 1-cycle registered latency.

Decomposition:
- Shared package (Defines.v) holds:
  - `RegNumWidth`.
  - Forward-select encodings FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - A stage-entry field layout macro.
- One natural sub-module: mdu_busy_counter, containing the load/decrement counter and busy flag.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x7 -> no stall; second op in EX gets fwdSelA=01, fwdSelB=00.
- One-gap dependency: add x5; nop; or x8,x5,x5 -> fwdSelA=fwdSelB=10.
- Load-use: lw x9 then add x10,x9,x0 -> 1 cycle of stallIF/stallID/bubbleEX = 1; add then sees fwdSelA=10; rs2 = x0 gives 00.
- x0 writer: addi x0 then add x1,x0,x0 -> fwdSel 00 both, no stall.
- MDU with MDU_LATENCY=4: mul x3 -> mduBusy high for 3 cycles, bubbleMEM 3 cycles; dependent next op gets fwdSel 01.
- Branch taken with simultaneous load-use condition in ID -> flushID=1, bubbleEX=1, stallIF=0. Mid-MDU rstn pulse -> all outputs 0 immediately, mduBusy stays 0 after release.
